// File: rtl/alu_operand_stack.sv
// Purpose: register-based operand stack feeding the ALU; top entry on alu_a, next entry on alu_b.
// Latency: a command takes effect on the accepting edge; outputs reflect it the following cycle.
// Backpressure: none; always ready, one command per cycle; illegal commands set sticky flags.

`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module alu_operand_stack #(
  parameter int WIDTH = `DATA_BITS,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CMD_NOP      = 3'b000,
    CMD_PUSH     = 3'b001,
    CMD_POP      = 3'b010,
    CMD_EXEC_UN  = 3'b011,
    CMD_EXEC_BIN = 3'b100,
    CMD_DUP      = 3'b101,
    CMD_SWAP     = 3'b110,
    CMD_CLEAR    = 3'b111
  } cmd_e;

  // Entry storage is deliberately unreset: anything at or above count is masked off the outputs.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_set;
  logic             unf_set;
  logic             flag_clr;

  // Slot indices derived from count. DEPTH is a power of two, so the low AW bits
  // of count address the next free slot, and modular subtraction gives top/next.
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nxt_idx;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] nxt_val;
  logic             is_empty;
  logic             is_full;
  logic             has_two;

  // Up to two storage writes per cycle (SWAP needs both).
  logic             wr0_en;
  logic [AW-1:0]    wr0_idx;
  logic [WIDTH-1:0] wr0_dat;
  logic             wr1_en;
  logic [AW-1:0]    wr1_idx;
  logic [WIDTH-1:0] wr1_dat;

  assign push_idx = count_q[AW-1:0];
  assign top_idx  = push_idx - AW'(1);
  assign nxt_idx  = push_idx - AW'(2);
  assign top_val  = mem[top_idx];
  assign nxt_val  = mem[nxt_idx];
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign has_two  = (count_q >= CW'(2));

  // Outputs decode only registered state; empty/short stacks present zeros.
  assign alu_a     = is_empty ? '0 : top_val;
  assign alu_b     = has_two  ? nxt_val : '0;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Command decode: legality checks, next count, storage writes and flag events.
  always_comb begin
    count_nxt = count_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    flag_clr  = 1'b0;
    wr0_en    = 1'b0;
    wr0_idx   = push_idx;
    wr0_dat   = push_data;
    wr1_en    = 1'b0;
    wr1_idx   = nxt_idx;
    wr1_dat   = top_val;
    if (cmd_valid) begin
      case (cmd_e'(cmd))
        CMD_PUSH: begin
          if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            wr0_en    = 1'b1;
            count_nxt = count_q + CW'(1);
          end
        end
        CMD_POP: begin
          if (is_empty) unf_set = 1'b1;
          else          count_nxt = count_q - CW'(1);
        end
        CMD_EXEC_UN: begin
          if (is_empty) begin
            unf_set = 1'b1;
          end else begin
            wr0_en  = 1'b1;
            wr0_idx = top_idx;
            wr0_dat = alu_result;
          end
        end
        CMD_EXEC_BIN: begin
          // Result lands in N's slot, which becomes the new top.
          if (!has_two) begin
            unf_set = 1'b1;
          end else begin
            wr0_en    = 1'b1;
            wr0_idx   = nxt_idx;
            wr0_dat   = alu_result;
            count_nxt = count_q - CW'(1);
          end
        end
        CMD_DUP: begin
          // Empty takes precedence: DUP on an empty stack is an underflow only.
          if (is_empty) begin
            unf_set = 1'b1;
          end else if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            wr0_en    = 1'b1;
            wr0_dat   = top_val;
            count_nxt = count_q + CW'(1);
          end
        end
        CMD_SWAP: begin
          if (!has_two) begin
            unf_set = 1'b1;
          end else begin
            wr0_en  = 1'b1;
            wr0_idx = top_idx;
            wr0_dat = nxt_val;
            wr1_en  = 1'b1;
          end
        end
        CMD_CLEAR: begin
          count_nxt = '0;
          flag_clr  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Stack depth register; reset discards every entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_nxt;
  end

  // Sticky error flags; CLEAR wins over any set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flag_clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  // Entry storage writes.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_dat;
    if (wr1_en) mem[wr1_idx] <= wr1_dat;
  end

endmodule

// File: tb/tb_alu_operand_stack.sv
// Purpose: self-checking bench for alu_operand_stack with a queue-based reference stack and a behavioural ALU.
// Latency: expectations are queued at drive time and checked one cycle later after the accepting edge.
// Backpressure: the DUT is always ready; the driver issues at most one command per cycle.

module tb_alu_operand_stack;

  localparam int W = 16;
  localparam int D = 16;

  localparam logic [2:0] C_NOP = 3'd0, C_PUSH = 3'd1, C_POP = 3'd2, C_UN = 3'd3,
                         C_BIN = 3'd4, C_DUP = 3'd5, C_SWAP = 3'd6, C_CLR = 3'd7;

  localparam logic [3:0] OP_INC = 4'd0, OP_DEC = 4'd1, OP_COMP = 4'd2, OP_SUM = 4'd3,
                         OP_SUB = 4'd4, OP_MULT = 4'd5, OP_DIV = 4'd6, OP_AND = 4'd7,
                         OP_OR = 4'd8, OP_XOR = 4'd9;

  typedef struct packed {
    logic [4:0]   cnt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         emp;
    logic         ful;
    logic         ovf;
    logic         unf;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd = 3'd0;
  logic [W-1:0] push_data = '0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [4:0]   count;
  logic         empty, full, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t         exp_q[$];
  logic [W-1:0] stk[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  always #5 clk = ~clk;

  alu_operand_stack #(.WIDTH(W), .DEPTH(D), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .push_data(push_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  // Behavioural ALU: a = top, b = next; SUB is next - top, DIV is next / top.
  function automatic logic [W-1:0] alu_f(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      OP_INC:  return a + 16'd1;
      OP_DEC:  return a - 16'd1;
      OP_COMP: return ~a;
      OP_SUM:  return b + a;
      OP_SUB:  return b - a;
      OP_MULT: return W'(b * a);
      OP_DIV:  return (a == '0) ? '1 : b / a;
      OP_AND:  return b & a;
      OP_OR:   return b | a;
      default: return b ^ a;
    endcase
  endfunction

  assign alu_result = alu_f(op, alu_a, alu_b);

  function automatic obs_t model_obs();
    obs_t o;
    int n = stk.size();
    o.cnt = 5'(n);
    o.a   = (n > 0) ? stk[n-1] : '0;
    o.b   = (n > 1) ? stk[n-2] : '0;
    o.emp = (n == 0);
    o.ful = (n == D);
    o.ovf = m_ovf;
    o.unf = m_unf;
    return o;
  endfunction

  // Reference stack semantics from the command rules, then queue the expected observation.
  task automatic apply_model(input logic [2:0] c, input logic [W-1:0] d, input logic [3:0] o);
    int n = stk.size();
    logic [W-1:0] ma = (n > 0) ? stk[n-1] : '0;
    logic [W-1:0] mb = (n > 1) ? stk[n-2] : '0;
    logic [W-1:0] r  = alu_f(o, ma, mb);
    case (c)
      C_PUSH: if (n == D) m_ovf = 1'b1; else stk.push_back(d);
      C_POP:  if (n == 0) m_unf = 1'b1; else void'(stk.pop_back());
      C_UN:   if (n == 0) m_unf = 1'b1; else stk[n-1] = r;
      C_BIN:  if (n < 2) m_unf = 1'b1;
              else begin void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(r); end
      C_DUP:  if (n == 0) m_unf = 1'b1; else if (n == D) m_ovf = 1'b1; else stk.push_back(ma);
      C_SWAP: if (n < 2) m_unf = 1'b1; else begin stk[n-1] = mb; stk[n-2] = ma; end
      C_CLR:  begin stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
      default: ;
    endcase
    exp_q.push_back(model_obs());
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [W-1:0] d, input logic [3:0] o);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; push_data = d; op = o;
    apply_model(c, d, o);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0; cmd = C_NOP;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: one queued expectation per accepted command, compared just after the edge.
  always @(posedge clk) begin
    obs_t e, act;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act = '{cnt: count, a: alu_a, b: alu_b, emp: empty, ful: full, ovf: overflow, unf: underflow};
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got cnt=%0d a=%0h b=%0h e=%0b f=%0b ov=%0b un=%0b, expected cnt=%0d a=%0h b=%0h e=%0b f=%0b ov=%0b un=%0b",
                 $time, act.cnt, act.a, act.b, act.emp, act.ful, act.ovf, act.unf,
                 e.cnt, e.a, e.b, e.emp, e.ful, e.ovf, e.unf);
      end
    end
  end

  initial begin
    logic [2:0] c;
    logic [3:0] o;
    int r;

    // Reset state
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_flags", {30'd0, overflow, underflow}, 0);
    #10 rst_n = 1'b1;

    do_cmd(C_PUSH, 16'd5, OP_INC);
    do_cmd(C_PUSH, 16'd3, OP_INC);
    idle();
    check("push_a", 32'(alu_a), 3);
    check("push_b", 32'(alu_b), 5);
    check("push_count", 32'(count), 2);

    // Binary exec
    do_cmd(C_BIN, 16'd0, OP_SUB);
    idle();
    check("sub_count", 32'(count), 1);
    check("sub_a", 32'(alu_a), 2);
    do_cmd(C_PUSH, 16'd4, OP_INC);
    do_cmd(C_BIN, 16'd0, OP_MULT);
    idle();
    check("mult_a", 32'(alu_a), 8);

    // Unary and reordering
    do_cmd(C_CLR, 16'd0, OP_INC);
    do_cmd(C_PUSH, 16'd7, OP_INC);
    do_cmd(C_UN, 16'd0, OP_INC);
    idle();
    check("inc_a", 32'(alu_a), 8);
    do_cmd(C_DUP, 16'd0, OP_INC);
    idle();
    check("dup_count", 32'(count), 2);
    check("dup_ab", {alu_a, alu_b}, {16'd8, 16'd8});
    do_cmd(C_PUSH, 16'd1, OP_INC);
    do_cmd(C_SWAP, 16'd0, OP_INC);
    idle();
    check("swap_ab", {alu_a, alu_b}, {16'd8, 16'd1});

    // Full and overflow
    do_cmd(C_CLR, 16'd0, OP_INC);
    for (int i = 1; i <= D; i++) do_cmd(C_PUSH, 16'(i), OP_INC);
    idle();
    check("full_flag", 32'(full), 1);
    check("full_a", 32'(alu_a), 16);
    do_cmd(C_PUSH, 16'd99, OP_INC);
    idle();
    check("ovf_a", 32'(alu_a), 16);
    check("ovf_count", 32'(count), 16);
    check("ovf_flag", 32'(overflow), 1);
    do_cmd(C_POP, 16'd0, OP_INC);
    idle();
    check("ovf_sticky", 32'(overflow), 1);

    // Underflow
    do_cmd(C_CLR, 16'd0, OP_INC);
    do_cmd(C_PUSH, 16'd9, OP_INC);
    do_cmd(C_BIN, 16'd0, OP_SUM);
    idle();
    check("unf_count", 32'(count), 1);
    check("unf_a", 32'(alu_a), 9);
    check("unf_flag", 32'(underflow), 1);
    do_cmd(C_POP, 16'd0, OP_INC);
    do_cmd(C_POP, 16'd0, OP_INC);
    idle();
    check("pop2_count", 32'(count), 0);
    check("pop2_a", 32'(alu_a), 0);
    do_cmd(C_CLR, 16'd0, OP_INC);
    idle();
    check("clr_flags", {30'd0, overflow, underflow}, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 35) c = C_PUSH;
      else if (r < 50) c = C_POP;
      else if (r < 60) c = C_UN;
      else if (r < 75) c = C_BIN;
      else if (r < 83) c = C_DUP;
      else if (r < 91) c = C_SWAP;
      else if (r < 93) c = C_CLR;
      else             c = C_NOP;
      if (c == C_UN) o = 4'($urandom_range(0, 2));
      else           o = 4'($urandom_range(3, 9));
      if ($urandom_range(0, 9) == 0) idle();
      do_cmd(c, 16'($urandom), o);
    end
    idle();

    // Async reset mid-burst
    do_cmd(C_CLR, 16'd0, OP_INC);
    do_cmd(C_PUSH, 16'd11, OP_INC);
    do_cmd(C_PUSH, 16'd12, OP_INC);
    do_cmd(C_PUSH, 16'd13, OP_INC);
    idle();
    check("pre_rst_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_a", 32'(alu_a), 0);
    stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    cmd_valid = 1'b1; cmd = C_PUSH; push_data = 16'd42; op = OP_INC;
    apply_model(C_PUSH, 16'd42, OP_INC);
    #1 rst_n = 1'b1;
    idle();
    check("post_rst_count", 32'(count), 1);
    check("post_rst_a", 32'(alu_a), 42);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_stack.md
# alu_operand_stack

Register-based operand stack sitting directly upstream of the ALU in the processor datapath. It holds the working operands, presents the top two entries to the ALU operand inputs every cycle, and writes the ALU result back on execute commands. It implements the stack-machine convention the ALU expects: `data_A` is the top entry and `data_B` is the next entry, so SUB yields next − top and DIV yields next / top.

## Interface
- `WIDTH`, default `` `DATA_BITS ``: entry width; must equal the ALU data width.
- `DEPTH`, default 16: number of entries; a power of two, minimum 4.
- `CW`, default `$clog2(DEPTH+1)`: width of the `count` output.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is present this cycle. The block is always ready and accepts one command per cycle.
- `cmd` in 3: command code. 000 NOP, 001 PUSH, 010 POP, 011 EXEC_UN, 100 EXEC_BIN, 101 DUP, 110 SWAP, 111 CLEAR.
- `push_data` in WIDTH: value written by PUSH.
- `alu_a` out WIDTH: top entry, or 0 when `count` is 0. Drives ALU `data_A`.
- `alu_b` out WIDTH: next entry, or 0 when `count` < 2. Drives ALU `data_B`.
- `alu_result` in WIDTH: combinational ALU result for the current `alu_a`/`alu_b`/op_code.
- `count` out CW: number of valid entries, 0..DEPTH.
- `empty` out 1: `count` == 0.
- `full` out 1: `count` == DEPTH.
- `overflow` out 1: sticky error flag.
- `underflow` out 1: sticky error flag.

## Operation
Commands act only when `cmd_valid` = 1. Let T be the top entry and N the next entry.

- **PUSH**: new top = `push_data`; `count` increases by 1.
- **POP**: discard T; `count` decreases by 1.
- **EXEC_UN**: T is replaced by `alu_result`; `count` is unchanged. Used for INC, DEC and COMP.
- **EXEC_BIN**: T and N are removed, then `alu_result` is pushed; `count` decreases by 1. Used for SUM, SUB, MULT, DIV, AND, OR and XOR.
- **DUP**: push a copy of T; `count` increases by 1.
- **SWAP**: exchange T and N.
- **CLEAR**: `count` = 0; clears both sticky flags.
- **NOP**: no effect.

Illegal commands leave the stack unchanged and set a flag:
- PUSH or DUP when `full` sets `overflow`.
- POP, EXEC_UN or DUP with `count` = 0 sets `underflow`.
- EXEC_BIN or SWAP with `count` < 2 sets `underflow`.

Rules on flags and storage:
- DUP on an empty stack sets `underflow` only, even though it is also a push.
- Flags are sticky until CLEAR or reset. CLEAR takes priority: after CLEAR both flags read 0.
- Entry storage needs no reset. Entries at or above `count` are never visible on the outputs.
- The block does not decode op_code. The controller issues the ALU op_code and the matching EXEC_UN or EXEC_BIN in the same cycle.

## Timing
- Reset (asynchronous, `rst_n` = 0): `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0, `alu_a` = 0, `alu_b` = 0. Asserting reset mid-sequence discards all entries immediately, without waiting for a clock edge.
- `alu_a`, `alu_b`, `count`, `empty` and `full` are decoded only from registered state. There is no combinational path from `cmd` or `push_data` to any output.
- `alu_result` is sampled at the same rising edge on which EXEC is accepted. The ALU path is purely combinational, so the result is captured with zero added latency.
- Every command takes effect at the edge it is accepted on. Updated outputs appear in the following cycle, so back-to-back commands are allowed every cycle.
- Sticky flags assert in the cycle after the illegal command.
- Wrap-around: none. The pointer saturates via the overflow and underflow checks and never wraps.

## Test plan
- **Reset.** Hold `rst_n` = 0 → `count` = 0, `empty` = 1, `alu_a` = `alu_b` = 0, both flags 0. Then PUSH 5 and PUSH 3 → `alu_a` = 3, `alu_b` = 5, `count` = 2.
- **Binary exec with real ALU.** Stack [5, 3 (top)], op SUB, EXEC_BIN → `count` = 1, `alu_a` = 2. Then PUSH 4, op MULT, EXEC_BIN → `alu_a` = 8.
- **Unary and reordering.** Stack [7], op INC, EXEC_UN → `alu_a` = 8. Then DUP → `count` = 2, `alu_a` = `alu_b` = 8. Then PUSH 1, SWAP → `alu_a` = 8, `alu_b` = 1.
- **Full and overflow.** Push DEPTH values 1..16 → `full` = 1, `alu_a` = 16. A 17th PUSH of 99 → `alu_a` still 16, `count` = 16, `overflow` = 1. Then POP → `overflow` stays 1.
- **Underflow.** Stack [9], EXEC_BIN → `count` = 1, `alu_a` = 9, `underflow` = 1. Then POP twice → `count` = 0, `alu_a` = 0. Then CLEAR → both flags 0.
- **Async reset mid-burst.** After 3 consecutive PUSHes, drop `rst_n` between clock edges → `count` = 0 immediately, with no clock edge needed. After release, the stack accepts a PUSH on the first edge.
